// File: rtl/regfile_dump_if.sv
// regfile_dump_if: register-file debug read port plus the outgoing byte-stream handshake.
interface regfile_dump_if #(parameter int AW = 5);
    logic          start;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic          done;
    modport master (input start, rd_data, tx_ready, output rd_addr, tx_data, tx_valid, busy, done);
    modport slave  (output start, rd_data, tx_ready, input rd_addr, tx_data, tx_valid, busy, done);
endinterface

// File: rtl/regfile_dump.sv
// regfile_dump: on start reads x0..x(NREGS-1) and streams them LSB-first, framed by
// a header byte and an XOR checksum of all data bytes.
module regfile_dump #(
    parameter int         NREGS    = 32,
    parameter int         AW       = 5,
    parameter logic [7:0] HDR_BYTE = 8'hA5
) (
    input logic            clk,
    input logic            rst,
    regfile_dump_if.master bus
);
    typedef enum logic [2:0] {IDLE, HDR, LOAD, BYTE, SUM, DONE} state_t;
    state_t        state;
    logic [AW-1:0] idx;
    logic [1:0]    cnt;
    logic [7:0]    csum;
    logic [31:0]   sbuf;
    logic          xfer;
    logic          last_reg;
    assign xfer        = bus.tx_valid && bus.tx_ready;
    assign last_reg    = idx == AW'(NREGS - 1);
    assign bus.rd_addr = idx;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            cnt          <= '0;
            csum         <= '0;
            sbuf         <= '0;
            bus.tx_data  <= '0;
            bus.tx_valid <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    state        <= HDR;
                    idx          <= '0;
                    cnt          <= '0;
                    csum         <= '0;
                    bus.tx_data  <= HDR_BYTE;
                    bus.tx_valid <= 1'b1;
                    bus.busy     <= 1'b1;
                end
                HDR: if (xfer) begin
                    state        <= LOAD;
                    bus.tx_valid <= 1'b0;
                end
                // The word is captured here only, so later register writes cannot tear it.
                LOAD: begin
                    sbuf         <= bus.rd_data;
                    cnt          <= '0;
                    bus.tx_data  <= bus.rd_data[7:0];
                    bus.tx_valid <= 1'b1;
                    state        <= BYTE;
                end
                BYTE: if (xfer) begin
                    csum <= csum ^ bus.tx_data;
                    sbuf <= sbuf >> 8;
                    cnt  <= cnt + 2'd1;
                    if (cnt != 2'd3) begin
                        bus.tx_data <= sbuf[15:8];
                    end else if (last_reg) begin
                        state       <= SUM;
                        bus.tx_data <= csum ^ bus.tx_data;
                    end else begin
                        idx          <= idx + AW'(1);
                        bus.tx_valid <= 1'b0;
                        state        <= LOAD;
                    end
                end
                SUM: if (xfer) begin
                    state        <= DONE;
                    bus.tx_valid <= 1'b0;
                    bus.busy     <= 1'b0;
                    bus.done     <= 1'b1;
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: frames checked byte-by-byte against a queue model built from the
// register contents at start, with random sink back-pressure and mid-frame disturbances.
module tb_regfile_dump;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_dump_if #(.AW(5)) bus();
    regfile_dump #(.NREGS(32), .AW(5), .HDR_BYTE(8'hA5)) dut (.clk(clk), .rst(rst), .bus(bus.master));

    logic [31:0] rf [32];
    assign bus.rd_data = rf[bus.rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;
    int test_id = 0, timeouts = 0;
    bit timed = 0, rmode = 0, fin = 0;

    logic [7:0] exp_q[$];
    int   phase = 0, t0 = 0, pos = 0, model_done = 0, dut_done = 0;
    bit   fin_done = 0;
    logic pv = 0, pr = 0;
    logic [7:0] pd = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void build();
        logic [7:0] x, v;
        x = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int r = 0; r < 32; r++)
            for (int b = 0; b < 4; b++) begin
                v = 8'(rf[r] >> (8 * b));
                exp_q.push_back(v);
                x ^= v;
            end
        exp_q.push_back(x);
    endfunction

    always @(negedge clk) begin
        int p, fc;
        logic [7:0] e, d;
        p  = phase;
        fc = cyc - t0;
        d  = bus.tx_data;
        if (rst) begin
            check("rst_tx_valid", bus.tx_valid, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_done", bus.done, 0);
            check("rst_tx_data", bus.tx_data, 0);
            check("rst_rd_addr", bus.rd_addr, 0);
            phase = 0;
            exp_q.delete();
            pv = 0;
        end else begin
            if (bus.done) dut_done++;
            check("busy", bus.busy, p == 1);
            check("done", bus.done, p == 2);
            if (p != 1) check("idle_tx_valid", bus.tx_valid, 0);
            if (pv && !pr) begin
                check("hold_tx_valid", bus.tx_valid, 1);
                check("hold_tx_data", d, pd);
            end
            if (timed && p == 1 && fc == 1) check("hdr_cycle_valid", bus.tx_valid, 1);
            if (timed && p == 1 && fc >= 2 && fc <= 161 && (fc - 2) % 5 == 0) begin
                check("load_rd_addr", bus.rd_addr, (fc - 2) / 5);
                check("load_bubble", bus.tx_valid, 0);
            end
            if (timed && bus.done) check("done_cycle", fc, 163);
            if (p == 1 && bus.tx_valid && bus.tx_ready) begin
                if (exp_q.size() == 0) check("extra_byte", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("byte", d, e);
                    if (pos == 0) check("hdr_lit", d, 8'hA5);
                    if (test_id == 1 && pos == 21) check("reg5_b0_lit", d, 8'hEF);
                    if (test_id == 1 && pos == 24) check("reg5_b3_lit", d, 8'hDE);
                    if (test_id == 1 && pos == 129) check("sum_lit", d, 8'h22);
                    if (test_id == 2 && pos >= 1 && pos < 129 && (pos - 1) % 4 == 0) check("idx_lit", d, (pos - 1) / 4);
                    if (test_id == 2 && pos == 129) check("sum_lit", d, 8'h00);
                    pos++;
                    if (exp_q.size() == 0) phase = 2;
                end
            end
            if (p == 2) begin
                phase = 0;
                model_done++;
            end
            if (p == 0 && bus.start) begin
                build();
                phase = 1;
                t0    = cyc;
                pos   = 0;
            end
            pv = bus.tx_valid;
            pr = bus.tx_ready;
            pd = d;
        end
        if (fin && !fin_done) begin
            fin_done = 1;
            check("timeouts", timeouts, 0);
            check("frames_done", model_done, 5);
            check("done_pulses", dut_done, model_done);
            check("queue_empty", exp_q.size(), 0);
        end
    end

    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 bus.tx_ready = rmode ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!bus.done && k < 3000) begin
            step();
            k++;
        end
        if (!bus.done) timeouts++;
    endtask

    task automatic wait_byte_of(input int r);
        int k = 0;
        while (!(bus.tx_valid && bus.rd_addr == 5'(r)) && k < 3000) begin
            step();
            k++;
        end
        if (k >= 3000) timeouts++;
    endtask

    task automatic load_sparse();
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[5] = 32'hDEADBEEF;
    endtask

    task automatic load_indexed();
        for (int i = 0; i < 32; i++) rf[i] = 32'h11223300 | 32'(i);
    endtask

    initial begin
        bus.start = 1'b0;
        load_sparse();
        repeat (3) step();
        rst = 1'b0;
        step();
        test_id = 1;
        timed   = 1;
        pulse_start();
        wait_done();
        repeat (3) step();
        load_indexed();
        test_id = 2;
        pulse_start();
        wait_done();
        repeat (3) step();
        // Back-pressured frame; reg7 changes after its LOAD and must not show up.
        load_sparse();
        test_id = 1;
        timed   = 0;
        rmode   = 1;
        step();
        pulse_start();
        wait_byte_of(7);
        rf[7] = 32'hFFFFFFFF;
        wait_done();
        rf[7] = 32'h0;
        repeat (3) step();
        rmode = 0;
        step();
        timed = 1;
        pulse_start();
        wait_byte_of(10);
        pulse_start();
        wait_done();
        pulse_start();
        repeat (3) step();
        timed = 0;
        rmode = 1;
        step();
        pulse_start();
        wait_byte_of(20);
        #1 rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        load_indexed();
        test_id = 2;
        step();
        pulse_start();
        wait_done();
        repeat (3) step();
        fin = 1;
        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
